// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard (scan set 2) deserialiser and make-code filter.
// Emits each key-press make code on ps2_out as a single-cycle pulse. Break (F0)
// and extended (E0) prefixes are consumed, releases and controller responses
// are dropped, and discarded frames pulse frame_error.
// Build option: define PS2_PARITY_CHECK_EN to enable the odd-parity check.
module ps2_scan_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_out,
  output logic       frame_error
);

  localparam int unsigned FCW = 8;
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SRW = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    DECODE = 2'd2
  } state_e;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic             filt_q;
  logic [FCW-1:0]   filt_cnt_q;
  state_e           state_q;
  logic [3:0]       bit_cnt_q;
  logic [SRW-1:0]   shift_q;
  logic [TOW-1:0]   to_cnt_q;
  logic             break_pending_q, ext_pending_q;
  logic [7:0]       ps2_out_q;
  logic             frame_error_q;

  logic             filt_done_c, fall_c;
  logic [7:0]       byte_c;
  logic             par_err_c, frame_ok_c, is_resp_c;

  // Two-flop synchronisers for both pins, idling high
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: accept a new clock level after FILTER_LEN consecutive cycles
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (clk_s2_q != filt_q) begin
      if (filt_done_c) begin
        filt_q     <= clk_s2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FCW'(1);
      end
    end else begin
      filt_cnt_q <= '0;
    end
  end

  // Edge detect, frame checks and byte classification
  always_comb begin
    filt_done_c = (filt_cnt_q == FCW'(FILTER_LEN - 1));
    fall_c      = filt_q & ~clk_s2_q & filt_done_c;
    byte_c      = shift_q[7:0];
`ifdef PS2_PARITY_CHECK_EN
    par_err_c   = ~(^shift_q[8:0]);
`else
    par_err_c   = 1'b0;
`endif
    frame_ok_c  = shift_q[9] & ~par_err_c;
    case (byte_c)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_resp_c = 1'b1;
      default:                                         is_resp_c = 1'b0;
    endcase
  end

  // Frame FSM: receive, timeout, decode and registered output pulses
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      to_cnt_q        <= '0;
      break_pending_q <= 1'b0;
      ext_pending_q   <= 1'b0;
      ps2_out_q       <= 8'h00;
      frame_error_q   <= 1'b0;
    end else begin
      ps2_out_q     <= 8'h00;
      frame_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_cnt_q <= '0;
          to_cnt_q  <= '0;
          if (fall_c && !dat_s2_q) state_q <= RECV;
        end
        RECV: begin
          if (fall_c) begin
            shift_q  <= {dat_s2_q, shift_q[SRW-1:1]};
            to_cnt_q <= '0;
            if (bit_cnt_q == 4'd9) begin
              bit_cnt_q <= '0;
              state_q   <= DECODE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            to_cnt_q      <= '0;
            frame_error_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TOW'(1);
          end
        end
        DECODE: begin
          state_q <= IDLE;
          if (!frame_ok_c) begin
            frame_error_q <= 1'b1;
          end else if (byte_c == 8'hE0) begin
            ext_pending_q <= 1'b1;
          end else if (byte_c == 8'hF0) begin
            break_pending_q <= 1'b1;
          end else if (!is_resp_c) begin
            if (!break_pending_q) ps2_out_q <= byte_c;
            break_pending_q <= 1'b0;
            ext_pending_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2_out     = ps2_out_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Testbench for ps2_scan_receiver: bit-level PS/2 host model with an
// expected-make-code queue and a negedge output monitor.
module tb_ps2_scan_receiver;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 40;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_out;
  logic       frame_error;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_arr [0:255];
  int         got_n = 0;
  int         rd = 0;
  int         fe_cnt = 0;
  int         fe_base = 0;
  int         viol = 0;
  logic [7:0] prev_out = 8'h00;

  ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_out     (ps2_out),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  // Monitor: record pulses away from the active edge, flag wide or overlapping pulses
  always @(negedge clock) begin
    if (ps2_out !== 8'h00) begin
      if (got_n < 256) got_arr[got_n] = ps2_out;
      got_n++;
      if (prev_out !== 8'h00) viol++;
      if (frame_error === 1'b1) viol++;
    end
    if (frame_error === 1'b1) fe_cnt++;
    prev_out = ps2_out;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF / 2);
  endtask

  // Full frame; push the byte as an expected pulse when want_pulse is set
  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic want_pulse);
    logic p;
    p = (~^b) ^ flip_par;
    if (want_pulse) exp_q.push_back(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    cyc(10);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    cyc(5);
    n_cmp++;
    if (ps2_out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", ps2_out); end
    n_cmp++;
    if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", frame_error); end
    resetn = 1'b1;
    cyc(20);
  endtask

  task automatic test_press;
    logic [7:0] e, g;
    send_frame(8'h34, 1'b0, 1'b1);
    cyc(50);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < got_n) ? got_arr[rd] : 8'h00;
      if (rd < got_n) rd++;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL press: ps2_out got %h want %h", g, e); end
    end
    n_cmp++;
    if (got_n != rd) begin n_fail++; $display("FAIL press_extra: %0d extra pulses want 0", got_n - rd); rd = got_n; end
    n_cmp++;
    if (fe_cnt - fe_base != 0) begin n_fail++; $display("FAIL press_fe: got %0d want 0", fe_cnt - fe_base); end
    fe_base = fe_cnt;
  endtask

  task automatic test_release;
    logic [7:0] e, g;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0);
    send_frame(8'h2D, 1'b0, 1'b1);
    // responses inside a release keep break pending
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'hFA, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0);
    send_frame(8'h23, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    cyc(50);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < got_n) ? got_arr[rd] : 8'h00;
      if (rd < got_n) rd++;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL release: ps2_out got %h want %h", g, e); end
    end
    n_cmp++;
    if (got_n != rd) begin n_fail++; $display("FAIL release_extra: %0d extra pulses want 0", got_n - rd); rd = got_n; end
    n_cmp++;
    if (fe_cnt - fe_base != 0) begin n_fail++; $display("FAIL release_fe: got %0d want 0", fe_cnt - fe_base); end
    fe_base = fe_cnt;
  endtask

  task automatic test_extended;
    logic [7:0] e, g;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h2B, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h2B, 1'b0, 1'b0);
    cyc(50);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < got_n) ? got_arr[rd] : 8'h00;
      if (rd < got_n) rd++;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL extended: ps2_out got %h want %h", g, e); end
    end
    n_cmp++;
    if (got_n != rd) begin n_fail++; $display("FAIL extended_extra: %0d extra pulses want 0", got_n - rd); rd = got_n; end
    n_cmp++;
    if (fe_cnt - fe_base != 0) begin n_fail++; $display("FAIL extended_fe: got %0d want 0", fe_cnt - fe_base); end
    fe_base = fe_cnt;
  endtask

  task automatic test_parity_and_stop;
    logic [7:0] e, g;
    int exp_fe;
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h2D, 1'b1, 1'b0);
    exp_fe = 1;
`else
    send_frame(8'h2D, 1'b1, 1'b1);
    exp_fe = 0;
`endif
    // bad stop bit always discards the frame
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(i[0]);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    exp_fe++;
    cyc(50);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < got_n) ? got_arr[rd] : 8'h00;
      if (rd < got_n) rd++;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL parity: ps2_out got %h want %h", g, e); end
    end
    n_cmp++;
    if (got_n != rd) begin n_fail++; $display("FAIL parity_extra: %0d extra pulses want 0", got_n - rd); rd = got_n; end
    n_cmp++;
    if (fe_cnt - fe_base != exp_fe) begin n_fail++; $display("FAIL parity_fe: got %0d want %0d", fe_cnt - fe_base, exp_fe); end
    fe_base = fe_cnt;
  endtask

  task automatic test_timeout;
    logic [7:0] e, g;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    cyc(TO + 100);
    n_cmp++;
    if (fe_cnt - fe_base != 1) begin n_fail++; $display("FAIL timeout_fe: got %0d want 1", fe_cnt - fe_base); end
    fe_base = fe_cnt;
    send_frame(8'h23, 1'b0, 1'b1);
    cyc(50);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < got_n) ? got_arr[rd] : 8'h00;
      if (rd < got_n) rd++;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL timeout_next: ps2_out got %h want %h", g, e); end
    end
    n_cmp++;
    if (got_n != rd) begin n_fail++; $display("FAIL timeout_extra: %0d extra pulses want 0", got_n - rd); rd = got_n; end
    n_cmp++;
    if (fe_cnt - fe_base != 0) begin n_fail++; $display("FAIL timeout_next_fe: got %0d want 0", fe_cnt - fe_base); end
    fe_base = fe_cnt;
  endtask

  task automatic test_glitch_reset;
    logic [7:0] e, g;
    // short low glitch must be filtered out
    ps2_clk = 1'b0;
    cyc(FL - 1);
    ps2_clk = 1'b1;
    cyc(30);
    // falling edge with data high in IDLE is ignored
    ps2_bit(1'b1);
    send_frame(8'h34, 1'b0, 1'b1);
    // reset mid-frame
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    resetn = 1'b0;
    cyc(3);
    n_cmp++;
    if (ps2_out !== 8'h00) begin n_fail++; $display("FAIL midreset_out: got %h want 00", ps2_out); end
    n_cmp++;
    if (frame_error !== 1'b0) begin n_fail++; $display("FAIL midreset_fe: got %b want 0", frame_error); end
    ps2_data = 1'b1;
    resetn = 1'b1;
    cyc(TO + 100);
    send_frame(8'h34, 1'b0, 1'b1);
    cyc(50);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < got_n) ? got_arr[rd] : 8'h00;
      if (rd < got_n) rd++;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL glitch_reset: ps2_out got %h want %h", g, e); end
    end
    n_cmp++;
    if (got_n != rd) begin n_fail++; $display("FAIL glitch_extra: %0d extra pulses want 0", got_n - rd); rd = got_n; end
    n_cmp++;
    if (fe_cnt - fe_base != 0) begin n_fail++; $display("FAIL glitch_fe: got %0d want 0", fe_cnt - fe_base); end
    fe_base = fe_cnt;
  endtask

  task automatic test_back_to_back;
    logic [7:0] e, g;
    for (int i = 0; i < 3; i++) send_frame(8'h34, 1'b0, 1'b1);
    send_frame(8'h1B, 1'b0, 1'b1);
    cyc(50);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (rd < got_n) ? got_arr[rd] : 8'h00;
      if (rd < got_n) rd++;
      n_cmp++;
      if (g !== e) begin n_fail++; $display("FAIL typematic: ps2_out got %h want %h", g, e); end
    end
    n_cmp++;
    if (got_n != rd) begin n_fail++; $display("FAIL typematic_extra: %0d extra pulses want 0", got_n - rd); rd = got_n; end
    n_cmp++;
    if (viol != 0) begin n_fail++; $display("FAIL pulse_shape: %0d wide or overlapping pulses want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_extended();
    test_parity_and_stop();
    test_timeout();
    test_glitch_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
